comparator_4bit_bf: RTL and testbench
=====================================

// Module: comparator_4bit_bf
// PURPOSE
// - Registered magnitude comparator for two WIDTH-bit operands a and b; default 4 bits.
// - Produces one-hot flags: e (a==b), g (a>b), l (a<b).
// - Used as a leaf compare stage in datapath and sort/select logic.
// - Behavioural-flow (RTL expression) implementation with a one-cycle registered output.
// PARAMETERS
// - WIDTH   4  operand width in bits, >=1
// - SIGNED  0  0 = unsigned compare; 1 = two's-complement compare
// PORTS
// - clk        input   1      rising-edge clock, the only clock
// - rst        input   1      asynchronous, active-high reset
// - in_valid   input   1      a/b are valid this cycle and are sampled
// - a          input   WIDTH  operand A
// - b          input   WIDTH  operand B
// - out_valid  output  1      e/g/l hold a result from the previous cycle's sample
// - e          output  1      a == b
// - g          output  1      a > b
// - l          output  1      a < b
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is asynchronous and active-high.
// - Reset (async assert, sync release): out_valid=0, e=0, g=0, l=0.
// - Latency is exactly 1 cycle.
//   - On a rising clk edge with in_valid=1, register e/g/l from the a/b present at that edge.
//   - out_valid=1 in the following cycle.
// - With in_valid=0: e/g/l hold their last values and out_valid=0 on the next edge.
// - Throughput: one compare per cycle. Back-to-back in_valid produces back-to-back results.
// - Invariant: once any result has been registered, exactly one of e/g/l is 1.
//   - After reset and before the first valid sample, all three are 0.
// - Unsigned (SIGNED=0): operands are 0..2^WIDTH-1.
//   - For WIDTH=4: a=4'hF, b=4'h0 gives g=1.
// - Signed (SIGNED=1): the MSB is the sign bit.
//   - For WIDTH=4: a=4'hF (-1), b=4'h0 gives l=1.
//   - a=4'h8 (-8) is below every other value.
// - Compare rule: MSB-first priority.
//   - The first differing bit from the MSB decides g/l.
//   - If no bit differs, e=1.
//   - In signed mode the MSB decision is inverted.
// - Boundaries:
//   - a=b=0: e=1.
//   - a=b=all-ones: e=1.
//   - Operands differing only in the LSB are resolved correctly.
// - If rst is asserted mid-stream, any in-flight result is discarded and outputs go to reset values immediately.
// - No X propagation from the flags when inputs are known.
//   - Do not use a default/else that leaves a flag unassigned.
// STRUCTURE
// - Shared package cmp_pkg:
//   - typedef cmp_res_t = {e,g,l} 3-bit one-hot.
//   - Constants CMP_EQ=3'b100, CMP_GT=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000.
// - Sub-module cmp_core: purely combinational, parameterised by WIDTH/SIGNED.
//   - Built from a per-bit equal/greater/less slice chain, MSB to LSB.
//   - Outputs cmp_res_t.
// - Top level:
//   - Instantiates cmp_core.
//   - Adds the in_valid capture register, the out_valid flop, and the async-reset result register.
// TESTING
// - Exhaustive, WIDTH=4, SIGNED=0:
//   - Drive all 256 {a,b} pairs 8'h00..8'hFF in order with in_valid=1.
//   - Each cycle, the previous pair's result matches a==b / a>b / a<b.
//   - Exactly one flag set; out_valid=1.
// - Reset:
//   - Assert rst asynchronously mid-stream with a=5, b=3 in flight.
//   - Outputs go to 0 immediately without waiting for clk; out_valid=0.
//   - After release, the first result appears 1 cycle after in_valid.
// - Hold:
//   - Sample a=9, b=9 (e=1), then in_valid=0 for 3 cycles with a=1, b=2.
//   - e stays 1, g=l=0, out_valid=0.
// - Boundaries, unsigned:
//   - a=F, b=E -> g=1.
//   - a=0, b=1 -> l=1.
//   - a=F, b=F -> e=1.
//   - a=8, b=7 -> g=1.
// - Signed, SIGNED=1:
//   - a=F, b=0 -> l=1.
//   - a=7, b=8 -> g=1.
//   - a=8, b=8 -> e=1.
// - Width, WIDTH=8, SIGNED=0:
//   - a=8'h80, b=8'h7F -> g=1.
//   - a=8'h01, b=8'h02 -> l=1.
//   - Back-to-back throughput is one result per cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared result encoding for the magnitude comparator family.
// Flags are packed {e,g,l} so a valid result is always one-hot.
package cmp_pkg;

   typedef logic [2:0] cmp_res_t;

   localparam cmp_res_t CMP_EQ   = 3'b100;
   localparam cmp_res_t CMP_GT   = 3'b010;
   localparam cmp_res_t CMP_LT   = 3'b001;
   localparam cmp_res_t CMP_NONE = 3'b000;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare, built as an MSB-to-LSB chain of bit slices.
// The first differing bit decides; in signed mode the sign bit's sense is flipped.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_res_t         res
);

   // Index WIDTH is the chain seed: nothing decided yet, still equal.
   logic [WIDTH:0] eq_c;
   logic [WIDTH:0] gt_c;
   logic [WIDTH:0] lt_c;

   assign eq_c[WIDTH] = 1'b1;
   assign gt_c[WIDTH] = 1'b0;
   assign lt_c[WIDTH] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      localparam bit INV = (SIGNED != 0) && (i == WIDTH - 1);
      logic bit_gt;
      logic bit_lt;

      // A set sign bit means negative, so a 1 against a 0 loses at the MSB.
      assign bit_gt = INV ? (~a[i] & b[i]) : (a[i] & ~b[i]);
      assign bit_lt = INV ? (a[i] & ~b[i]) : (~a[i] & b[i]);

      assign eq_c[i] = eq_c[i+1] & ~(a[i] ^ b[i]);
      assign gt_c[i] = gt_c[i+1] | (eq_c[i+1] & bit_gt);
      assign lt_c[i] = lt_c[i+1] | (eq_c[i+1] & bit_lt);
   end

   assign res = {eq_c[0], gt_c[0], lt_c[0]};

endmodule

// File: rtl/comparator_4bit_bf.sv
// Registered magnitude comparator: one compare per cycle, one cycle latency.
// Flags hold their last result while in_valid is low; out_valid marks fresh results.
module comparator_4bit_bf
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             e,
   output logic             g,
   output logic             l
);

   cmp_res_t cmp_w;
   cmp_res_t res_d;
   cmp_res_t res_q;
   logic     out_valid_q;

   cmp_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .a   (a),
      .b   (b),
      .res (cmp_w)
   );

   assign res_d = in_valid ? cmp_w : res_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q       <= CMP_NONE;
         out_valid_q <= 1'b0;
      end else begin
         res_q       <= res_d;
         out_valid_q <= in_valid;
      end
   end

   assign out_valid   = out_valid_q;
   assign {e, g, l}   = res_q;

endmodule

// File: tb/tb_comparator_4bit_bf.sv
// Scoreboard bench for comparator_4bit_bf: unsigned 4-bit, signed 4-bit and unsigned 8-bit
// instances; expected {out_valid,e,g,l} is queued at drive time and popped one cycle later.
module tb_comparator_4bit_bf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       v4, vs, v8;
   logic [3:0] a4, b4, as_, bs;
   logic [7:0] a8, b8;
   logic       ov4, e4, g4, l4;
   logic       ovs, es, gs, ls;
   logic       ov8, e8, g8, l8;

   comparator_4bit_bf #(.WIDTH(4), .SIGNED(0)) u4 (
      .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
      .out_valid(ov4), .e(e4), .g(g4), .l(l4));
   comparator_4bit_bf #(.WIDTH(4), .SIGNED(1)) us (
      .clk(clk), .rst(rst), .in_valid(vs), .a(as_), .b(bs),
      .out_valid(ovs), .e(es), .g(gs), .l(ls));
   comparator_4bit_bf #(.WIDTH(8), .SIGNED(0)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
      .out_valid(ov8), .e(e8), .g(g8), .l(l8));

   int nvec = 0;
   int nerr = 0;

   logic [3:0] q4[$], qs[$], q8[$];
   logic [2:0] last4 = 3'b000, lasts = 3'b000, last8 = 3'b000;

   function automatic logic [2:0] ref_u(input int unsigned x, input int unsigned y);
      if (x == y) return 3'b100;
      else if (x > y) return 3'b010;
      else return 3'b001;
   endfunction

   function automatic logic [2:0] ref_s4(input logic [3:0] x, input logic [3:0] y);
      int sx, sy;
      sx = x[3] ? int'(x) - 16 : int'(x);
      sy = y[3] ? int'(y) - 16 : int'(y);
      if (sx == sy) return 3'b100;
      else if (sx > sy) return 3'b010;
      else return 3'b001;
   endfunction

   task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic v);
      a4 = x; b4 = y; v4 = v;
      if (v) last4 = ref_u(x, y);
      q4.push_back({v, last4});
   endtask

   task automatic drives(input logic [3:0] x, input logic [3:0] y, input logic v);
      as_ = x; bs = y; vs = v;
      if (v) lasts = ref_s4(x, y);
      qs.push_back({v, lasts});
   endtask

   task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic v);
      a8 = x; b8 = y; v8 = v;
      if (v) last8 = ref_u(x, y);
      q8.push_back({v, last8});
   endtask

   task automatic test_reset;
      logic [3:0] got;
      #1;
      got = {ov4, e4, g4, l4}; nvec++;
      if (got !== 4'b0000) begin nerr++; $display("FAIL reset_u4: got %b want 0000", got); end
      got = {ovs, es, gs, ls}; nvec++;
      if (got !== 4'b0000) begin nerr++; $display("FAIL reset_s4: got %b want 0000", got); end
      got = {ov8, e8, g8, l8}; nvec++;
      if (got !== 4'b0000) begin nerr++; $display("FAIL reset_u8: got %b want 0000", got); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_exhaustive;
      logic [3:0] got, exp;
      for (int i = 0; i <= 256; i++) begin
         @(negedge clk);
         if (q4.size() != 0) begin
            exp = q4.pop_front(); got = {ov4, e4, g4, l4}; nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL exhaustive pair %0d: got %b want %b", i - 1, got, exp);
            end
         end
         if (i < 256) drive4(i[7:4], i[3:0], 1'b1);
         else v4 = 1'b0;
      end
   endtask

   task automatic test_hold;
      logic [3:0] got, exp;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (q4.size() != 0) begin
            exp = q4.pop_front(); got = {ov4, e4, g4, l4}; nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL hold step %0d: got %b want %b", i, got, exp);
            end
         end
         if (i == 0) drive4(4'd9, 4'd9, 1'b1);
         else if (i < 4) drive4(4'd1, 4'd2, 1'b0);
         else v4 = 1'b0;
      end
   endtask

   task automatic test_boundary_u;
      logic [7:0] tab [6] = '{8'hFE, 8'h01, 8'hFF, 8'h87, 8'h00, 8'hEF};
      logic [3:0] got, exp;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (q4.size() != 0) begin
            exp = q4.pop_front(); got = {ov4, e4, g4, l4}; nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL boundary_u %h: got %b want %b", tab[i-1], got, exp);
            end
         end
         if (i < 6) drive4(tab[i][7:4], tab[i][3:0], 1'b1);
         else v4 = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0] got, exp;
      @(negedge clk);
      drive4(4'd5, 4'd3, 1'b1);
      @(posedge clk);
      #2;
      exp = q4.pop_front(); got = {ov4, e4, g4, l4}; nvec++;
      if (got !== exp) begin nerr++; $display("FAIL pre_reset: got %b want %b", got, exp); end
      rst = 1'b1;
      #1;
      got = {ov4, e4, g4, l4}; nvec++;
      if (got !== 4'b0000) begin nerr++; $display("FAIL async_reset: got %b want 0000", got); end
      q4.delete(); last4 = 3'b000; lasts = 3'b000; last8 = 3'b000;
      @(negedge clk);
      got = {ov4, e4, g4, l4}; nvec++;
      if (got !== 4'b0000) begin nerr++; $display("FAIL reset_held: got %b want 0000", got); end
      rst = 1'b0;
      drive4(4'd6, 4'd6, 1'b1);
      @(negedge clk);
      exp = q4.pop_front(); got = {ov4, e4, g4, l4}; nvec++;
      if (got !== exp) begin nerr++; $display("FAIL post_reset_first: got %b want %b", got, exp); end
      v4 = 1'b0;
   endtask

   task automatic test_signed;
      logic [7:0] tab [6] = '{8'hF0, 8'h78, 8'h88, 8'h87, 8'h0F, 8'h8F};
      logic [3:0] got, exp;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (qs.size() != 0) begin
            exp = qs.pop_front(); got = {ovs, es, gs, ls}; nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL signed %h: got %b want %b", tab[i-1], got, exp);
            end
         end
         if (i < 6) drives(tab[i][7:4], tab[i][3:0], 1'b1);
         else vs = 1'b0;
      end
   endtask

   task automatic test_wide_b2b;
      logic [15:0] tab [4] = '{16'h807F, 16'h0102, 16'hFFFF, 16'h0000};
      logic [15:0] vec;
      logic [3:0]  got, exp;
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk);
         if (q8.size() != 0) begin
            exp = q8.pop_front(); got = {ov8, e8, g8, l8}; nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL wide step %0d: got %b want %b", i - 1, got, exp);
            end
         end
         if (i < 4) begin
            vec = tab[i];
            drive8(vec[15:8], vec[7:0], 1'b1);
         end else if (i < 12) begin
            vec = 16'($urandom_range(0, 65535));
            drive8(vec[15:8], vec[7:0], 1'b1);
         end else v8 = 1'b0;
      end
   endtask

   initial begin
      v4 = 1'b0; vs = 1'b0; v8 = 1'b0;
      a4 = '0; b4 = '0; as_ = '0; bs = '0; a8 = '0; b8 = '0;
      test_reset;
      test_exhaustive;
      test_hold;
      test_boundary_u;
      test_reset_mid;
      test_signed;
      test_wide_b2b;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
